// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings: transfer types, response codes and slave FSM states.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR1 = 2'b10,
    S_ERR2 = 2'b11
  } slv_state_t;

endpackage

// File: rtl/ahb_slave_port_if.sv
// AHB-lite bus bundle between a master and one slave endpoint.
interface ahb_slave_port_if
  import ahb_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 16
);
  logic                 hsel;
  logic [ADDRWIDTH-1:0] haddr;
  logic                 hwrite;
  htrans_t              htrans;
  logic [DATAWIDTH-1:0] hwdata;
  logic                 hready;
  logic                 hreadyout;
  hresp_t               hresp;
  logic [DATAWIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, htrans, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, htrans, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// Word array with one synchronous write port and a registered read port that
// forwards write data when both ports hit the same index on the same edge.
module ahb_slave_mem #(
  parameter int DATAWIDTH = 16,
  parameter int DEPTH     = 64,
  localparam int IDXW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [IDXW-1:0]      waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic                 re,
  input  logic [IDXW-1:0]      raddr,
  output logic [DATAWIDTH-1:0] rdata
);
  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [DATAWIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[raddr == waddr ? waddr : waddr] <= wdata;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/ahb_slave_port.sv
// AHB-lite slave endpoint fronting a local register array with programmable wait states.
// Define AHB_SLV_ERR_EN to answer out-of-range addresses with a two-cycle ERROR response.
module ahb_slave_port
  import ahb_pkg::*;
#(
  parameter int DATAWIDTH   = 16,
  parameter int ADDRWIDTH   = 16,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input logic             hclk,
  input logic             hrst_n,
  ahb_slave_port_if.slave bus
);
  localparam int ADDR_LSB = $clog2(DATAWIDTH / 8);
  localparam int IDXW     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  slv_state_t     state_reg;
  logic           hreadyout_reg;
  hresp_t         hresp_reg;
  logic           dp_valid_reg;
  logic           dp_write_reg;
  logic [IDXW-1:0] dp_idx_reg;
  logic [3:0]     wait_cnt_reg;

  logic            accept;
  logic            legal;
  logic [IDXW-1:0] idx;
  logic            write_en;
  logic            read_en;
  logic [IDXW-1:0] read_idx;
  logic [DATAWIDTH-1:0] rdata;
  logic            unused;

  assign idx    = bus.haddr[ADDR_LSB +: IDXW];
  assign accept = bus.hsel & bus.hready & bus.htrans[1] & hreadyout_reg;
`ifdef AHB_SLV_ERR_EN
  assign legal  = ~|(bus.haddr >> (ADDR_LSB + IDXW));
`else
  assign legal  = 1'b1;
`endif
  assign unused = ^{bus.haddr, bus.htrans};

  // A write commits on the edge that ends its data phase; reset discards it.
  assign write_en = hrst_n & dp_valid_reg & dp_write_reg & hreadyout_reg;
  // Reads load hrdata on the edge that enters the completing cycle.
  assign read_en  = hrst_n & ((accept & ~bus.hwrite & legal & (WAIT_STATES == 0)) |
                              ((state_reg == S_WAIT) & (wait_cnt_reg == 4'd0) & ~dp_write_reg));
  assign read_idx = (state_reg == S_WAIT) ? dp_idx_reg : idx;

  always_ff @(posedge hclk) begin
    if (!hrst_n) begin
      state_reg     <= S_IDLE;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= HRESP_OKAY;
      dp_valid_reg  <= 1'b0;
      dp_write_reg  <= 1'b0;
      dp_idx_reg    <= '0;
      wait_cnt_reg  <= 4'd0;
    end else begin
      case (state_reg)
        S_WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg     <= S_IDLE;
            hreadyout_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
`ifdef AHB_SLV_ERR_EN
        S_ERR1: begin
          state_reg     <= S_ERR2;
          hreadyout_reg <= 1'b1;
        end
`endif
        default: begin
          // S_IDLE and S_ERR2: complete any data phase and accept a new transfer.
          state_reg     <= S_IDLE;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= HRESP_OKAY;
          dp_valid_reg  <= 1'b0;
          if (accept) begin
            if (!legal) begin
              state_reg     <= S_ERR1;
              hreadyout_reg <= 1'b0;
              hresp_reg     <= HRESP_ERROR;
            end else begin
              dp_valid_reg <= 1'b1;
              dp_write_reg <= bus.hwrite;
              dp_idx_reg   <= idx;
              if (WAIT_STATES > 0) begin
                state_reg     <= S_WAIT;
                hreadyout_reg <= 1'b0;
                wait_cnt_reg  <= WAIT_LOAD;
              end
            end
          end
        end
      endcase
    end
  end

  ahb_slave_mem #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk   (hclk),
    .rst_n (hrst_n),
    .we    (write_en),
    .waddr (dp_idx_reg),
    .wdata (bus.hwdata),
    .re    (read_en),
    .raddr (read_idx),
    .rdata (rdata)
  );

  assign bus.hreadyout = hreadyout_reg;
  assign bus.hresp     = hresp_reg;
  assign bus.hrdata    = rdata;
endmodule

// File: tb/tb_ahb_slave_port.sv
// Directed bench for ahb_slave_port: a zero-wait instance (A) and a two-wait instance (B).
// Error-test expectations follow AHB_SLV_ERR_EN.
module tb_ahb_slave_port;
  import ahb_pkg::*;

  logic clk = 1'b0;
  logic hrst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ahb_slave_port_if #(.DATAWIDTH(16), .ADDRWIDTH(16)) bus_a ();
  ahb_slave_port_if #(.DATAWIDTH(16), .ADDRWIDTH(16)) bus_b ();
  assign bus_a.hready = bus_a.hreadyout;
  assign bus_b.hready = bus_b.hreadyout;

  ahb_slave_port #(.DATAWIDTH(16), .ADDRWIDTH(16), .DEPTH(64), .WAIT_STATES(0)) dut_a (
    .hclk(clk), .hrst_n(hrst_n), .bus(bus_a));
  ahb_slave_port #(.DATAWIDTH(16), .ADDRWIDTH(16), .DEPTH(64), .WAIT_STATES(2)) dut_b (
    .hclk(clk), .hrst_n(hrst_n), .bus(bus_b));

`ifdef AHB_SLV_ERR_EN
  localparam logic [15:0] IDX0_EXP = 16'h5555;
`else
  localparam logic [15:0] IDX0_EXP = 16'hFFFF;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic sel, input htrans_t trans, input logic wr, input logic [15:0] addr);
    bus_a.hsel = sel; bus_a.htrans = trans; bus_a.hwrite = wr; bus_a.haddr = addr;
  endtask

  task automatic b_drive(input logic sel, input htrans_t trans, input logic wr, input logic [15:0] addr);
    bus_b.hsel = sel; bus_b.htrans = trans; bus_b.hwrite = wr; bus_b.haddr = addr;
  endtask

  task automatic a_write(input logic [15:0] addr, input logic [15:0] data);
    a_drive(1'b1, HTRANS_NONSEQ, 1'b1, addr);
    tick();
    bus_a.hwdata = data;
    a_drive(1'b1, HTRANS_IDLE, 1'b0, 16'h0);
    tick();
    $display("A wr addr=%h data=%h", addr, data);
  endtask

  task automatic a_read(input logic [15:0] addr, output logic [15:0] data);
    a_drive(1'b1, HTRANS_NONSEQ, 1'b0, addr);
    tick();
    a_drive(1'b1, HTRANS_IDLE, 1'b0, 16'h0);
    data = bus_a.hrdata;
    $display("A rd addr=%h data=%h", addr, data);
  endtask

  task automatic b_write(input logic [15:0] addr, input logic [15:0] data, output int lows);
    b_drive(1'b1, HTRANS_NONSEQ, 1'b1, addr);
    tick();
    bus_b.hwdata = data;
    b_drive(1'b1, HTRANS_IDLE, 1'b0, 16'h0);
    lows = 0;
    while (bus_b.hreadyout !== 1'b1 && lows < 20) begin
      lows++;
      tick();
    end
    tick();
    $display("B wr addr=%h data=%h waits=%0d", addr, data, lows);
  endtask

  task automatic b_read(input logic [15:0] addr, output logic [15:0] data, output int lows);
    b_drive(1'b1, HTRANS_NONSEQ, 1'b0, addr);
    tick();
    b_drive(1'b1, HTRANS_IDLE, 1'b0, 16'h0);
    lows = 0;
    while (bus_b.hreadyout !== 1'b1 && lows < 20) begin
      lows++;
      tick();
    end
    data = bus_b.hrdata;
    $display("B rd addr=%h data=%h waits=%0d", addr, data, lows);
  endtask

  task automatic test_reset();
    hrst_n = 1'b0;
    a_drive(1'b0, HTRANS_IDLE, 1'b0, 16'h0);
    b_drive(1'b0, HTRANS_IDLE, 1'b0, 16'h0);
    bus_a.hwdata = '0; bus_b.hwdata = '0;
    tick(); tick();
    hrst_n = 1'b1;
    tick();
    n_checks++; if (bus_a.hreadyout !== 1'b1) $display("FAIL reset_a_hreadyout got=%b exp=1", bus_a.hreadyout); else n_pass++;
    n_checks++; if (bus_a.hresp !== 2'b00) $display("FAIL reset_a_hresp got=%b exp=00", bus_a.hresp); else n_pass++;
    n_checks++; if (bus_a.hrdata !== 16'h0) $display("FAIL reset_a_hrdata got=%h exp=0000", bus_a.hrdata); else n_pass++;
    n_checks++; if (bus_b.hreadyout !== 1'b1) $display("FAIL reset_b_hreadyout got=%b exp=1", bus_b.hreadyout); else n_pass++;
    n_checks++; if (bus_b.hresp !== 2'b00) $display("FAIL reset_b_hresp got=%b exp=00", bus_b.hresp); else n_pass++;
    n_checks++; if (bus_b.hrdata !== 16'h0) $display("FAIL reset_b_hrdata got=%h exp=0000", bus_b.hrdata); else n_pass++;
  endtask

  task automatic test_forwarding();
    logic [15:0] d;
    a_drive(1'b1, HTRANS_NONSEQ, 1'b1, 16'h0004);
    tick();
    bus_a.hwdata = 16'hA5A5;
    n_checks++; if (bus_a.hreadyout !== 1'b1) $display("FAIL fwd_wr_ready got=%b exp=1", bus_a.hreadyout); else n_pass++;
    a_drive(1'b1, HTRANS_NONSEQ, 1'b0, 16'h0004);
    tick();
    a_drive(1'b1, HTRANS_IDLE, 1'b0, 16'h0);
    $display("A wr+rd addr=0004 data=%h", bus_a.hrdata);
    n_checks++; if (bus_a.hreadyout !== 1'b1) $display("FAIL fwd_rd_ready got=%b exp=1", bus_a.hreadyout); else n_pass++;
    n_checks++; if (bus_a.hrdata !== 16'hA5A5) $display("FAIL fwd_rd_data got=%h exp=a5a5", bus_a.hrdata); else n_pass++;
    // Write to idx4 while reading idx3: the read must see the array, not hwdata.
    a_write(16'h0006, 16'h0606);
    a_drive(1'b1, HTRANS_NONSEQ, 1'b1, 16'h0008);
    tick();
    bus_a.hwdata = 16'h0808;
    a_drive(1'b1, HTRANS_NONSEQ, 1'b0, 16'h0006);
    tick();
    a_drive(1'b1, HTRANS_IDLE, 1'b0, 16'h0);
    n_checks++; if (bus_a.hrdata !== 16'h0606) $display("FAIL nofwd_rd_data got=%h exp=0606", bus_a.hrdata); else n_pass++;
    a_read(16'h0008, d);
    n_checks++; if (d !== 16'h0808) $display("FAIL nofwd_wr_commit got=%h exp=0808", d); else n_pass++;
  endtask

  task automatic test_wait_states();
    logic [15:0] d;
    int lows;
    b_write(16'h0002, 16'h1234, lows);
    n_checks++; if (lows != 2) $display("FAIL ws_wr_waits got=%0d exp=2", lows); else n_pass++;
    b_read(16'h0002, d, lows);
    n_checks++; if (lows != 2) $display("FAIL ws_rd_waits got=%0d exp=2", lows); else n_pass++;
    n_checks++; if (d !== 16'h1234) $display("FAIL ws_rd_data got=%h exp=1234", d); else n_pass++;
    n_checks++; if (bus_b.hresp !== 2'b00) $display("FAIL ws_rd_hresp got=%b exp=00", bus_b.hresp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    int lows;
    b_write(16'h0004, 16'h1111, lows);
    b_drive(1'b1, HTRANS_NONSEQ, 1'b1, 16'h0004);
    tick();
    bus_b.hwdata = 16'hBEEF;
    b_drive(1'b1, HTRANS_IDLE, 1'b0, 16'h0);
    n_checks++; if (bus_b.hreadyout !== 1'b0) $display("FAIL rstmid_in_wait got=%b exp=0", bus_b.hreadyout); else n_pass++;
    hrst_n = 1'b0;
    tick();
    n_checks++; if (bus_b.hreadyout !== 1'b1) $display("FAIL rstmid_hreadyout got=%b exp=1", bus_b.hreadyout); else n_pass++;
    n_checks++; if (bus_b.hresp !== 2'b00) $display("FAIL rstmid_hresp got=%b exp=00", bus_b.hresp); else n_pass++;
    n_checks++; if (bus_b.hrdata !== 16'h0) $display("FAIL rstmid_hrdata got=%h exp=0000", bus_b.hrdata); else n_pass++;
    tick();
    hrst_n = 1'b1;
    tick();
    b_read(16'h0004, d, lows);
    n_checks++; if (d !== 16'h1111) $display("FAIL rstmid_write_lost got=%h exp=1111", d); else n_pass++;
  endtask

  task automatic test_error();
    logic [15:0] d;
    a_write(16'h0000, 16'h5555);
    a_drive(1'b1, HTRANS_NONSEQ, 1'b1, 16'h0100);
    tick();
    bus_a.hwdata = 16'hFFFF;
    a_drive(1'b1, HTRANS_IDLE, 1'b0, 16'h0);
`ifdef AHB_SLV_ERR_EN
    n_checks++; if (bus_a.hreadyout !== 1'b0) $display("FAIL err_c1_ready got=%b exp=0", bus_a.hreadyout); else n_pass++;
    n_checks++; if (bus_a.hresp !== 2'b01) $display("FAIL err_c1_hresp got=%b exp=01", bus_a.hresp); else n_pass++;
    tick();
    n_checks++; if (bus_a.hreadyout !== 1'b1) $display("FAIL err_c2_ready got=%b exp=1", bus_a.hreadyout); else n_pass++;
    n_checks++; if (bus_a.hresp !== 2'b01) $display("FAIL err_c2_hresp got=%b exp=01", bus_a.hresp); else n_pass++;
    tick();
    n_checks++; if (bus_a.hresp !== 2'b00) $display("FAIL err_c3_hresp got=%b exp=00", bus_a.hresp); else n_pass++;
`else
    n_checks++; if (bus_a.hreadyout !== 1'b1) $display("FAIL alias_ready got=%b exp=1", bus_a.hreadyout); else n_pass++;
    n_checks++; if (bus_a.hresp !== 2'b00) $display("FAIL alias_hresp got=%b exp=00", bus_a.hresp); else n_pass++;
    tick();
`endif
    a_read(16'h0000, d);
    n_checks++; if (d !== IDX0_EXP) $display("FAIL err_idx0 got=%h exp=%h", d, IDX0_EXP); else n_pass++;
  endtask

  task automatic test_burst();
    logic [15:0] rd_exp;
    a_drive(1'b1, HTRANS_NONSEQ, 1'b1, 16'h0010);
    tick();
    bus_a.hwdata = 16'h0001;
    a_drive(1'b1, HTRANS_SEQ, 1'b1, 16'h0012);
    tick();
    bus_a.hwdata = 16'h0002;
    a_drive(1'b1, HTRANS_BUSY, 1'b1, 16'h0014);
    tick();
    bus_a.hwdata = 16'hDEAD;
    n_checks++; if (bus_a.hreadyout !== 1'b1) $display("FAIL busy_ready got=%b exp=1", bus_a.hreadyout); else n_pass++;
    n_checks++; if (bus_a.hresp !== 2'b00) $display("FAIL busy_hresp got=%b exp=00", bus_a.hresp); else n_pass++;
    a_drive(1'b1, HTRANS_SEQ, 1'b1, 16'h0014);
    tick();
    bus_a.hwdata = 16'h0003;
    a_drive(1'b1, HTRANS_SEQ, 1'b1, 16'h0016);
    tick();
    bus_a.hwdata = 16'h0004;
    a_drive(1'b1, HTRANS_NONSEQ, 1'b0, 16'h0010);
    tick();
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) a_drive(1'b1, HTRANS_SEQ, 1'b0, 16'(16'h0010 + 2 * i));
      else       a_drive(1'b1, HTRANS_IDLE, 1'b0, 16'h0);
      rd_exp = 16'(i);
      $display("A burst rd beat=%0d data=%h", i, bus_a.hrdata);
      n_checks++; if (bus_a.hrdata !== rd_exp) $display("FAIL burst_rd_beat%0d got=%h exp=%h", i, bus_a.hrdata, rd_exp); else n_pass++;
      tick();
    end
  endtask

  task automatic test_deselect();
    logic [15:0] d;
    a_drive(1'b0, HTRANS_NONSEQ, 1'b1, 16'h0000);
    tick();
    bus_a.hwdata = 16'hBAD0;
    a_drive(1'b1, HTRANS_IDLE, 1'b0, 16'h0);
    n_checks++; if (bus_a.hreadyout !== 1'b1) $display("FAIL desel_ready got=%b exp=1", bus_a.hreadyout); else n_pass++;
    tick();
    a_read(16'h0000, d);
    n_checks++; if (d !== IDX0_EXP) $display("FAIL desel_idx0 got=%h exp=%h", d, IDX0_EXP); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_wait_states();
    test_reset_mid();
    test_error();
    test_burst();
    test_deselect();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
